// File: rtl/ssd_scan_decoder.sv
// Seven-segment scan monitor: recovers per-digit 5-bit codes from a multiplexed active-low anode/segment bus.
// Latency: a dwell is captured STABLE_CYCLES+1 edges after the pins settle; outputs are registered.
// Backpressure: none; the input is a free-running sampled bus, and each settled dwell is captured exactly once.
module ssd_scan_decoder #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DIGITS-1:0]     an_in,
    input  logic [6:0]            seg_in,
    output logic [5*DIGITS-1:0]   codes_out,
    output logic [DIGITS-1:0]     digit_valid,
    output logic                  frame_done,
    output logic                  decode_err
);

    localparam logic [3:0] CNT_MAX   = 4'(STABLE_CYCLES - 1);
    localparam logic [4:0] CODE_BLANK = 5'd27;
    localparam logic [4:0] CODE_BAD   = 5'd31;

    typedef enum logic {SETTLE, HELD} state_t;

    state_t              state;
    logic [DIGITS-1:0]   s_an, p_an;
    logic [6:0]          s_seg, p_seg;
    logic [3:0]          cnt;
    logic [DIGITS-1:0]   mask;

    // Where two codes share a pattern, the lower code is the one listed.
    function automatic logic [4:0] decode(input logic [6:0] seg);
        logic [4:0] code;
        case (seg)
            7'b0000001: code = 5'd0;
            7'b1001111: code = 5'd1;
            7'b0010010: code = 5'd2;
            7'b0000110: code = 5'd3;
            7'b1001100: code = 5'd4;
            7'b0100100: code = 5'd5;
            7'b0100000: code = 5'd6;
            7'b0001111: code = 5'd7;
            7'b0000000: code = 5'd8;
            7'b0001100: code = 5'd9;
            7'b0001000: code = 5'd10;
            7'b0110001: code = 5'd12;
            7'b0110000: code = 5'd14;
            7'b0111000: code = 5'd15;
            7'b1110001: code = 5'd16;
            7'b1000010: code = 5'd17;
            7'b0011000: code = 5'd18;
            7'b1111110: code = 5'd19;
            7'b1101010: code = 5'd20;
            7'b1111010: code = 5'd21;
            7'b1100011: code = 5'd22;
            7'b1110010: code = 5'd23;
            7'b1110000: code = 5'd24;
            7'b1000100: code = 5'd25;
            7'b1111111: code = 5'd27;
            default:    code = CODE_BAD;
        endcase
        return code;
    endfunction

    logic                changed;
    logic                capture;
    logic [DIGITS-1:0]   cap_bit;
    logic [4:0]          cap_code;
    logic [DIGITS-1:0]   mask_next;

    always_comb begin
        changed   = {s_an, s_seg} != {p_an, p_seg};
        cap_bit   = ~s_an;
        cap_code  = decode(s_seg);
        mask_next = mask | cap_bit;
        // Blanking (no low anode) and overlapping anodes are simply ignored.
        capture   = (state == SETTLE) && !changed && (cnt == CNT_MAX) && $onehot(cap_bit);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_an        <= '1;
            p_an        <= '1;
            s_seg       <= '1;
            p_seg       <= '1;
            cnt         <= '0;
            state       <= SETTLE;
            mask        <= '0;
            codes_out   <= {DIGITS{CODE_BLANK}};
            digit_valid <= '0;
            frame_done  <= 1'b0;
            decode_err  <= 1'b0;
        end else begin
            s_an       <= an_in;
            s_seg      <= seg_in;
            p_an       <= s_an;
            p_seg      <= s_seg;
            frame_done <= 1'b0;
            decode_err <= 1'b0;
            if (changed) begin
                cnt   <= '0;
                state <= SETTLE;
            end else begin
                if (cnt != CNT_MAX)
                    cnt <= cnt + 4'd1;
                if (capture) begin
                    state <= HELD;
                    for (int i = 0; i < DIGITS; i++)
                        if (cap_bit[i])
                            codes_out[5*i +: 5] <= cap_code;
                    digit_valid <= digit_valid | cap_bit;
                    decode_err  <= (cap_code == CODE_BAD);
                    if (&mask_next) begin
                        frame_done <= 1'b1;
                        mask       <= (mask == '0) ? cap_bit : '0;
                    end else begin
                        mask <= mask_next;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ssd_scan_decoder.sv
// Bench for ssd_scan_decoder: directed scenarios plus random dwells against a run-length reference model.
module tb_ssd_scan_decoder;

    localparam int DIGITS = 4;
    localparam int S      = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic [DIGITS-1:0]   an_in;
    logic [6:0]          seg_in;
    logic [5*DIGITS-1:0] codes_out;
    logic [DIGITS-1:0]   digit_valid;
    logic                frame_done;
    logic                decode_err;

    int tests_run    = 0;
    int tests_failed = 0;

    ssd_scan_decoder #(.DIGITS(DIGITS), .STABLE_CYCLES(S)) dut (
        .clk        (clk),
        .rst        (rst),
        .an_in      (an_in),
        .seg_in     (seg_in),
        .codes_out  (codes_out),
        .digit_valid(digit_valid),
        .frame_done (frame_done),
        .decode_err (decode_err)
    );

    always #5 clk = ~clk;

    // Encoder view of the display: code -> pattern. Decoding searches for the lowest matching code.
    logic [6:0] enc_pat [25] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
        7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0001100,
        7'b0001000, 7'b0110001, 7'b0110000, 7'b0111000, 7'b1110001,
        7'b1000010, 7'b0011000, 7'b1111110, 7'b1101010, 7'b1111010,
        7'b1100011, 7'b1110010, 7'b1110000, 7'b1000100, 7'b1111111};
    int enc_code [25] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 12, 14, 15, 16,
                          17, 18, 19, 20, 21, 22, 23, 24, 25, 27};

    function automatic logic [4:0] ref_decode(input logic [6:0] seg);
        int best = 31;
        for (int i = 0; i < 25; i++)
            if (enc_pat[i] == seg && enc_code[i] < best)
                best = enc_code[i];
        return 5'(best);
    endfunction

    // Reference state: expected outputs plus the current run of identical samples.
    logic [5*DIGITS-1:0] m_codes;
    logic [DIGITS-1:0]   m_valid, m_mask;
    logic                m_frame, m_err;
    logic [DIGITS+6:0]   m_last;
    int                  m_run;

    // Drives one cycle of pins, advances the model at the edge, returns 1ns after the edge.
    task automatic step(input logic r, input logic [DIGITS-1:0] an, input logic [6:0] seg);
        logic [4:0]        code;
        logic [DIGITS-1:0] bitv;
        rst    = r;
        an_in  = an;
        seg_in = seg;
        @(posedge clk);
        m_frame = 1'b0;
        m_err   = 1'b0;
        if (r) begin
            m_codes = {DIGITS{5'd27}};
            m_valid = '0;
            m_mask  = '0;
            m_last  = '1;
            m_run   = 1;
        end else begin
            // A dwell is taken once, when S+1 identical samples have been seen.
            bitv = ~m_last[DIGITS+6:7];
            if (m_run == S + 1 && $countones(bitv) == 1) begin
                code = ref_decode(m_last[6:0]);
                for (int d = 0; d < DIGITS; d++)
                    if (bitv[d]) m_codes[5*d +: 5] = code;
                m_valid |= bitv;
                m_err = (code == 5'd31);
                if ((m_mask | bitv) == '1) begin
                    m_frame = 1'b1;
                    m_mask  = (m_mask == '0) ? bitv : '0;
                end else begin
                    m_mask |= bitv;
                end
            end
            if ({an, seg} == m_last) begin
                if (m_run < S + 2) m_run++;
            end else begin
                m_last = {an, seg};
                m_run  = 1;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        step(1'b1, '1, '1);
        step(1'b1, 4'b1110, 7'b0000000);
        tests_run++;
        if (codes_out !== {DIGITS{5'd27}}) begin
            tests_failed++;
            $display("FAIL reset_codes: got %h, expected %h", codes_out, {DIGITS{5'd27}});
        end
        tests_run++;
        if ({digit_valid, frame_done, decode_err} !== 6'b0) begin
            tests_failed++;
            $display("FAIL reset_flags: got valid=%b fd=%b err=%b, expected all 0", digit_valid, frame_done, decode_err);
        end
    endtask

    task automatic test_single_digit();
        int caps = 0;
        int cap_step = -1;
        step(1'b1, '1, '1);
        for (int k = 1; k <= 10; k++) begin
            step(1'b0, 4'b1110, 7'b0010010);
            if (digit_valid[0] && cap_step < 0) cap_step = k;
            caps += (codes_out[4:0] == 5'd2 && cap_step == k) ? 1 : 0;
            tests_run++;
            if ({codes_out, digit_valid, frame_done, decode_err} !== {m_codes, m_valid, m_frame, m_err}) begin
                tests_failed++;
                $display("FAIL single_cyc%0d: got %h/%b/%b/%b, expected %h/%b/%b/%b", k,
                         codes_out, digit_valid, frame_done, decode_err, m_codes, m_valid, m_frame, m_err);
            end
        end
        tests_run++;
        if (cap_step !== S + 2 || caps !== 1 || digit_valid !== 4'b0001) begin
            tests_failed++;
            $display("FAIL single_latency: got step=%0d caps=%0d valid=%b, expected step=%0d caps=1 valid=0001",
                     cap_step, caps, digit_valid, S + 2);
        end
    endtask

    task automatic test_scan();
        logic [6:0] pats [4] = '{7'b0000110, 7'b1001100, 7'b0001000, 7'b1111111};
        int fd_cnt = 0;
        step(1'b1, '1, '1);
        for (int pass = 0; pass < 2; pass++)
            for (int d = 0; d < DIGITS; d++)
                for (int k = 0; k < 8; k++) begin
                    step(1'b0, ~(4'b1 << d), pats[d]);
                    fd_cnt += int'(frame_done);
                    tests_run++;
                    if ({codes_out, digit_valid, frame_done, decode_err} !== {m_codes, m_valid, m_frame, m_err}) begin
                        tests_failed++;
                        $display("FAIL scan_p%0d_d%0d_c%0d: got %h/%b/%b/%b, expected %h/%b/%b/%b", pass, d, k,
                                 codes_out, digit_valid, frame_done, decode_err, m_codes, m_valid, m_frame, m_err);
                    end
                end
        tests_run++;
        if (codes_out !== {5'd27, 5'd10, 5'd4, 5'd3} || digit_valid !== 4'b1111 || fd_cnt !== 2) begin
            tests_failed++;
            $display("FAIL scan_final: got codes=%h valid=%b pulses=%0d, expected codes=%h valid=1111 pulses=2",
                     codes_out, digit_valid, fd_cnt, {5'd27, 5'd10, 5'd4, 5'd3});
        end
    endtask

    task automatic test_glitch();
        int bad = 0;
        step(1'b1, '1, '1);
        for (int k = 0; k < 18; k++) begin
            step(1'b0, 4'b1011, (k == 8 || k == 9) ? 7'b1111110 : 7'b0000000);
            bad += (codes_out[14:10] == 5'd19) ? 1 : 0;
            tests_run++;
            if ({codes_out, digit_valid, frame_done, decode_err} !== {m_codes, m_valid, m_frame, m_err}) begin
                tests_failed++;
                $display("FAIL glitch_cyc%0d: got %h/%b/%b/%b, expected %h/%b/%b/%b", k,
                         codes_out, digit_valid, frame_done, decode_err, m_codes, m_valid, m_frame, m_err);
            end
        end
        tests_run++;
        if (bad !== 0 || codes_out[14:10] !== 5'd8) begin
            tests_failed++;
            $display("FAIL glitch_final: got field2=%0d glitch_cycles=%0d, expected field2=8 glitch_cycles=0",
                     codes_out[14:10], bad);
        end
    endtask

    task automatic test_blank();
        int errs = 0;
        step(1'b1, '1, '1);
        for (int k = 0; k < 20; k++) begin
            step(1'b0, (k < 10) ? 4'b1111 : 4'b1100, 7'b0000001);
            errs += int'(decode_err);
        end
        tests_run++;
        if (codes_out !== {DIGITS{5'd27}} || digit_valid !== 4'b0 || errs !== 0) begin
            tests_failed++;
            $display("FAIL blank: got codes=%h valid=%b errs=%0d, expected codes=%h valid=0000 errs=0",
                     codes_out, digit_valid, errs, {DIGITS{5'd27}});
        end
    endtask

    task automatic test_unmapped();
        logic [6:0] pats [3] = '{7'b1010101, 7'b0000000, 7'b0100100};
        int errs = 0;
        step(1'b1, '1, '1);
        for (int p = 0; p < 3; p++) begin
            for (int k = 0; k < 8; k++) begin
                step(1'b0, 4'b1101, pats[p]);
                errs += int'(decode_err);
                if (decode_err) begin
                    tests_run++;
                    if (codes_out[9:5] !== 5'd31 || digit_valid[1] !== 1'b1) begin
                        tests_failed++;
                        $display("FAIL unmapped_coincide: got field1=%0d valid1=%b, expected 31 and 1",
                                 codes_out[9:5], digit_valid[1]);
                    end
                end
            end
            tests_run++;
            if (codes_out[9:5] !== ref_decode(pats[p])) begin
                tests_failed++;
                $display("FAIL unmapped_field_p%0d: got %0d, expected %0d", p, codes_out[9:5], ref_decode(pats[p]));
            end
        end
        tests_run++;
        if (errs !== 1) begin
            tests_failed++;
            $display("FAIL unmapped_err_count: got %0d, expected 1", errs);
        end
    endtask

    task automatic test_reset_mid();
        int cap_step = -1;
        step(1'b1, '1, '1);
        step(1'b0, 4'b1011, 7'b0001111);
        step(1'b0, 4'b1011, 7'b0001111);
        step(1'b1, 4'b1011, 7'b0001111);
        tests_run++;
        if (codes_out !== {DIGITS{5'd27}} || digit_valid !== 4'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_clear: got codes=%h valid=%b, expected all 27 and 0000", codes_out, digit_valid);
        end
        for (int k = 1; k <= 8; k++) begin
            step(1'b0, 4'b1011, 7'b0001111);
            if (digit_valid[2] && cap_step < 0) cap_step = k;
        end
        tests_run++;
        if (cap_step !== S + 2 || codes_out[14:10] !== 5'd7) begin
            tests_failed++;
            $display("FAIL reset_mid_recapture: got step=%0d field2=%0d, expected step=%0d field2=7",
                     cap_step, codes_out[14:10], S + 2);
        end
    endtask

    task automatic test_rst_vs_capture();
        step(1'b1, '1, '1);
        for (int k = 0; k < S + 1; k++) step(1'b0, 4'b0111, 7'b0000110);
        step(1'b1, 4'b0111, 7'b0000110);
        tests_run++;
        if (digit_valid !== 4'b0 || codes_out !== {DIGITS{5'd27}}) begin
            tests_failed++;
            $display("FAIL rst_wins: got codes=%h valid=%b, expected all 27 and 0000", codes_out, digit_valid);
        end
    endtask

    task automatic test_random();
        logic [DIGITS-1:0] an;
        logic [6:0]        seg;
        int                len;
        step(1'b1, '1, '1);
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 7))
                0:       an = '1;
                1:       an = 4'($urandom);
                default: an = ~(4'b1 << $urandom_range(0, DIGITS - 1));
            endcase
            seg = ($urandom_range(0, 1) != 0) ? enc_pat[$urandom_range(0, 24)] : 7'($urandom);
            len = $urandom_range(1, 9);
            for (int k = 0; k < len; k++) begin
                step(($urandom_range(0, 59) == 0), an, seg);
                tests_run++;
                if ({codes_out, digit_valid, frame_done, decode_err} !== {m_codes, m_valid, m_frame, m_err}) begin
                    tests_failed++;
                    $display("FAIL random_n%0d_c%0d: got %h/%b/%b/%b, expected %h/%b/%b/%b", n, k,
                             codes_out, digit_valid, frame_done, decode_err, m_codes, m_valid, m_frame, m_err);
                end
            end
        end
    endtask

    initial begin
        rst    = 1'b1;
        an_in  = '1;
        seg_in = '1;
        test_reset();
        test_single_digit();
        test_scan();
        test_glitch();
        test_blank();
        test_unmapped();
        test_reset_mid();
        test_rst_vs_capture();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
